// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: register file geometry and writeback requester slots.
package cpu_pkg;
  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request found at or after ptr
// (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, plus a
// pending-write scoreboard that the issue stage uses for hazard stalls.
module regs_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 reg_write,
  output logic [AW-1:0]        wt_addr,
  output logic [DW-1:0]        wt_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_conflict,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [NUM_REGS-1:0]  pending
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       r_ptr;
  logic                r_reg_write;
  logic [AW-1:0]       r_wt_addr;
  logic [DW-1:0]       r_wt_data;
  logic [NUM_REGS-1:0] r_pending;

  logic [NREQ-1:0]     w_gnt;
  logic                w_xfer;
  logic [PW-1:0]       w_gnt_idx;
  logic [PW-1:0]       w_ptr_next;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_data;
  logic [NUM_REGS-1:0] w_pending_next;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // Grants are suppressed while reset is held so no requester sees a transfer.
  assign req_ready = w_gnt & {NREQ{~rst}};
  assign w_xfer    = |req_ready;

  always_comb begin
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = PW'(i);
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Clear follows the committed write; a same-address reservation overrides it.
  always_comb begin
    w_pending_next = r_pending;
    if (r_reg_write)
      w_pending_next[r_wt_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0))
      w_pending_next[rsv_addr] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_reg_write <= 1'b0;
      r_wt_addr   <= '0;
      r_wt_data   <= '0;
      r_pending   <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_xfer) begin
        r_ptr       <= w_ptr_next;
        r_reg_write <= (w_sel_addr != '0);
        r_wt_addr   <= w_sel_addr;
        r_wt_data   <= w_sel_data;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  assign reg_write    = r_reg_write;
  assign wt_addr      = r_wt_addr;
  assign wt_data      = r_wt_data;
  assign pending      = r_pending;
  assign rs1_busy     = (rs1_addr != '0) && r_pending[rs1_addr];
  assign rs2_busy     = (rs2_addr != '0) && r_pending[rs2_addr];
  assign rsv_conflict = rsv_valid && (rsv_addr != '0) && r_pending[rsv_addr];
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback sources, for example ALU, load unit and multi-cycle mul/div.
- Arbitration is round-robin. One grant per cycle, with a registered write port feeding the register file (RegWrite/Wt_addr/Wt_data).
- Holds a pending-write scoreboard for r1–r31 so the issue/hazard logic can stall reads of registers with an outstanding writeback.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  requester i presents a write.
- req_addr  in  NREQ*AW  packed destination addresses; slice i = [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; slice i = [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant (or zero); transfer when valid&ready.
- reg_write  out  1  to register file RegWrite.
- wt_addr  out  AW  to register file Wt_addr.
- wt_data  out  DW  to register file Wt_data.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  AW  register being reserved.
- rsv_conflict  out  1  rsv_addr already pending (combinational).
- rs1_addr, rs2_addr  in  AW  source registers of the instruction in issue.
- rs1_busy, rs2_busy  out  1  corresponding source pending (combinational).
- pending  out  32  scoreboard bitmap; bit 0 constant 0.

Behaviour:
- Reset (async, rst=1): reg_write=0, wt_addr=0, wt_data=0, pending=0, rr pointer=0. req_ready stays 0 while rst is high.
- Arbitration (combinational):
  - Search order starts at rr pointer p: p, p+1, …, NREQ-1, 0, … p-1.
  - The first valid requester gets req_ready; at most one bit set. No valid requester → req_ready=0.
- Pointer update: on a grant to i, p ← (i+1) mod NREQ at the clock edge. No grant → p unchanged.
- Write port (registered, latency 1):
  - On a transfer, at the edge: reg_write←1, wt_addr←req_addr[i], wt_data←req_data[i].
  - The register file captures it at the following edge.
  - No transfer → reg_write←0; wt_addr/wt_data hold their previous values.
- x0 writes: a transfer to addr 0 is accepted (ready given) but reg_write←0. It still advances the pointer.
- Requester rule: req_addr/req_data stay stable while valid&&!ready. Valid is not withdrawn before the grant. The bench checks this with assertions; the RTL does not need to handle violations.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Scoreboard:
  - Set: pending[a]←1 at the edge when rsv_valid && a!=0.
  - Clear: pending[wt_addr]←0 at the edge when reg_write=1, i.e. the same edge the register file writes.
  - Set and clear of the same address at the same edge: set wins.
  - Set and clear of different addresses at the same edge: both apply.
- Read-side outputs:
  - rs1_busy = (rs1_addr!=0) && pending[rs1_addr]; rs2_busy likewise.
  - rsv_conflict = rsv_valid && rsv_addr!=0 && pending[rsv_addr].
  - Issue logic stalls on conflict. If a reservation is made anyway, the bit stays 1 and the first completing write clears it; this is caller error.
- Reset mid-operation: everything returns to reset values immediately. In-flight registered writes are dropped (reg_write=0), so the register file sees no write.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW=5, REG_DW=32, NUM_REGS=32.
  - Requester index constants WB_ALU=0, WB_LSU=1, WB_MDU=2.
- One sub-module rr_arbiter: parameter N; inputs req, ptr; output one-hot gnt. Purely combinational, reused later for memory-port sharing.
- Scoreboard and write-port registers live in the top.

Test Plan:
- Single request: req_valid=001, addr=5, data=0xDEADBEEF → ready=001 same cycle; next cycle reg_write=1, wt_addr=5, wt_data=0xDEADBEEF; the cycle after, reg_write=0.
- Round-robin fairness: all three requesters held valid for 6 cycles from reset → grant sequence 0,1,2,0,1,2; exactly one ready bit set per cycle.
- x0 write: requester 1 valid, addr=0 → ready asserted, reg_write stays 0, pointer advances to 2.
- Scoreboard:
  - rsv addr 7 → pending[7]=1 next cycle and rs1_busy=1 when rs1_addr=7.
  - Later write to 7 commits → pending[7]=0 after the edge where reg_write=1.
  - rsv_addr=0 never sets a bit.
- Simultaneous set/clear: reg_write=1 with wt_addr=9 and rsv_valid with rsv_addr=9 on the same edge → pending[9]=1. With rsv_addr=10 → pending[9]=0 and pending[10]=1.
- Async reset mid-stream: assert rst between edges while reg_write=1 and pending=0x0000_0480 → outputs 0 immediately, with no clock edge needed; after release, first grant goes to requester 0.
